// File: rtl/reduce_arbiter_if.sv
// Handshake bundle for reduce_arbiter: two requesters,
// one response consumer and the shared reduction unit.
interface reduce_arbiter_if #(
  parameter int WIDTH = 4
) ();
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_data;
  logic [1:0]       req0_op;
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_data;
  logic [1:0]       req1_op;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic             rsp_result;
  logic             rsp_error;
  logic             ru_start;
  logic [WIDTH-1:0] ru_in;
  logic [1:0]       ru_op;
  logic             ru_done;
  logic             ru_result;

  modport master (
    output req0_valid, req0_data, req0_op,
    input  req0_ready,
    output req1_valid, req1_data, req1_op,
    input  req1_ready,
    input  rsp_valid, rsp_id, rsp_result, rsp_error,
    output rsp_ready,
    input  ru_start, ru_in, ru_op,
    output ru_done, ru_result
  );

  modport slave (
    input  req0_valid, req0_data, req0_op,
    output req0_ready,
    input  req1_valid, req1_data, req1_op,
    output req1_ready,
    output rsp_valid, rsp_id, rsp_result, rsp_error,
    input  rsp_ready,
    output ru_start, ru_in, ru_op,
    input  ru_done, ru_result
  );
endinterface

// File: rtl/reduce_arbiter.sv
// Round-robin arbiter sharing one reduction unit between two
// requesters, with a bounded wait and timeout error response.
module reduce_arbiter #(
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic             CLK,
  input  logic             ASYNCRESETN,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_data,
  input  logic [1:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_data,
  input  logic [1:0]       req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic             rsp_result,
  output logic             rsp_error,
  output logic             ru_start,
  output logic [WIDTH-1:0] ru_in,
  output logic [1:0]       ru_op,
  input  logic             ru_done,
  input  logic             ru_result
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  state_t     state_nx;
  logic       last_grant;
  logic [7:0] cnt;
  logic       gnt1;
  logic       gnt0;
  logic       idle;
  logic       accept;
  logic       timeout;

  // Tie goes to whoever was not served last.
  assign gnt1 = req1_valid & (~req0_valid | ~last_grant);
  assign gnt0 = req0_valid & ~gnt1;

  assign idle       = (state == IDLE) & ASYNCRESETN;
  assign req0_ready = idle & gnt0;
  assign req1_ready = idle & gnt1;
  assign accept     = req0_ready | req1_ready;

  assign timeout   = (cnt == TO_LAST);
  assign ru_start  = (state == ISSUE);
  assign rsp_valid = (state == RESP);

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (accept) state_nx = ISSUE;
      ISSUE: state_nx = WAIT;
      WAIT:  if (ru_done || timeout) state_nx = RESP;
      RESP:  if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      ru_in      <= '0;
      ru_op      <= '0;
      rsp_id     <= 1'b0;
      rsp_result <= 1'b0;
      rsp_error  <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= '0;
    end else begin
      if (accept) begin
        ru_in  <= gnt1 ? req1_data : req0_data;
        ru_op  <= gnt1 ? req1_op : req0_op;
        rsp_id <= gnt1;
      end
      if (state == ISSUE) begin
        cnt <= '0;
      end
      // A done pulse on the timeout cycle still counts as success.
      if (state == WAIT) begin
        cnt <= cnt + 8'd1;
        if (ru_done) begin
          rsp_result <= ru_result;
          rsp_error  <= 1'b0;
        end else if (timeout) begin
          rsp_result <= 1'b0;
          rsp_error  <= 1'b1;
        end
      end
      if (state == RESP && rsp_ready) begin
        last_grant <= rsp_id;
      end
    end
  end

endmodule

// File: tb/tb_reduce_arbiter.sv
// Directed bench for reduce_arbiter; the bench plays the
// requesters, the consumer and the reduction unit.
module tb_reduce_arbiter;

  logic CLK = 1'b0;
  logic ASYNCRESETN;

  always #5 CLK = ~CLK;

  reduce_arbiter_if #(.WIDTH(4)) bus ();

  reduce_arbiter #(.WIDTH(4), .TIMEOUT(15)) dut (
    .CLK        (CLK),
    .ASYNCRESETN(ASYNCRESETN),
    .req0_valid (bus.req0_valid),
    .req0_ready (bus.req0_ready),
    .req0_data  (bus.req0_data),
    .req0_op    (bus.req0_op),
    .req1_valid (bus.req1_valid),
    .req1_ready (bus.req1_ready),
    .req1_data  (bus.req1_data),
    .req1_op    (bus.req1_op),
    .rsp_valid  (bus.rsp_valid),
    .rsp_ready  (bus.rsp_ready),
    .rsp_id     (bus.rsp_id),
    .rsp_result (bus.rsp_result),
    .rsp_error  (bus.rsp_error),
    .ru_start   (bus.ru_start),
    .ru_in      (bus.ru_in),
    .ru_op      (bus.ru_op),
    .ru_done    (bus.ru_done),
    .ru_result  (bus.ru_result)
  );

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Caller has set the valids; this is cycle 0 of the operation.
  task automatic run_op(input string tag, input int lat,
                        input logic res, input logic id,
                        input logic [3:0] din, input logic [1:0] op,
                        input logic hold);
    #1;
    chk({tag, ":rdy0"}, 32'(bus.req0_ready), 32'(id == 1'b0));
    chk({tag, ":rdy1"}, 32'(bus.req1_ready), 32'(id == 1'b1));
    tick();
    if (!hold) begin
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      #1;
    end
    chk({tag, ":start"}, 32'(bus.ru_start), 32'd1);
    chk({tag, ":ru_in"}, 32'(bus.ru_in), 32'(din));
    chk({tag, ":ru_op"}, 32'(bus.ru_op), 32'(op));
    chk({tag, ":rdy_busy"},
        32'(bus.req0_ready | bus.req1_ready), 32'd0);
    repeat (lat) tick();
    bus.ru_done   = 1'b1;
    bus.ru_result = res;
    #1;
    chk({tag, ":early_rsp"}, 32'(bus.rsp_valid), 32'd0);
    tick();
    bus.ru_done   = 1'b0;
    bus.ru_result = 1'b0;
    #1;
    chk({tag, ":rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
    chk({tag, ":rsp_id"}, 32'(bus.rsp_id), 32'(id));
    chk({tag, ":rsp_result"}, 32'(bus.rsp_result), 32'(res));
    chk({tag, ":rsp_error"}, 32'(bus.rsp_error), 32'd0);
    tick();
  endtask

  // Requester id alone, unit silent except optionally on the last cycle.
  task automatic to_op(input string tag, input logic id,
                       input logic late_done);
    if (id) bus.req1_valid = 1'b1;
    else    bus.req0_valid = 1'b1;
    #1;
    chk({tag, ":rdy"}, 32'(id ? bus.req1_ready : bus.req0_ready), 32'd1);
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    #1;
    chk({tag, ":start"}, 32'(bus.ru_start), 32'd1);
    tick();
    repeat (14) tick();
    bus.ru_done   = late_done;
    bus.ru_result = late_done;
    #1;
    chk({tag, ":c16_valid"}, 32'(bus.rsp_valid), 32'd0);
    tick();
    bus.ru_done   = 1'b0;
    bus.ru_result = 1'b0;
    #1;
    chk({tag, ":c17_valid"}, 32'(bus.rsp_valid), 32'd1);
    chk({tag, ":error"}, 32'(bus.rsp_error), 32'(!late_done));
    chk({tag, ":result"}, 32'(bus.rsp_result), 32'(late_done));
    chk({tag, ":id"}, 32'(bus.rsp_id), 32'(id));
    tick();
    chk({tag, ":idle"}, 32'(bus.rsp_valid), 32'd0);
  endtask

  task automatic do_reset();
    ASYNCRESETN = 1'b0;
    #1;
    chk("rst:rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst:ru_in", 32'(bus.ru_in), 32'd0);
    chk("rst:ru_op", 32'(bus.ru_op), 32'd0);
    chk("rst:rsp_id", 32'(bus.rsp_id), 32'd0);
    tick();
    ASYNCRESETN = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    ASYNCRESETN    = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req0_data  = 4'h0;
    bus.req0_op    = 2'd0;
    bus.req1_valid = 1'b0;
    bus.req1_data  = 4'h0;
    bus.req1_op    = 2'd0;
    bus.rsp_ready  = 1'b1;
    bus.ru_done    = 1'b0;
    bus.ru_result  = 1'b0;
    #2;
    chk("init:rdy0", 32'(bus.req0_ready), 32'd0);
    chk("init:start", 32'(bus.ru_start), 32'd0);
    chk("init:rsp_result", 32'(bus.rsp_result), 32'd0);
    chk("init:rsp_error", 32'(bus.rsp_error), 32'd0);
    bus.req0_valid = 1'b0;
    do_reset();

    // Single request, L=2, AND|OR of all ones
    bus.req0_valid = 1'b1;
    bus.req0_data  = 4'b1111;
    bus.req0_op    = 2'b11;
    run_op("single", 2, 1'b1, 1'b0, 4'b1111, 2'b11, 1'b0);
    chk("single:idle", 32'(bus.rsp_valid), 32'd0);

    // Both requesters busy: strict alternation
    do_reset();
    bus.req0_valid = 1'b1;
    bus.req0_data  = 4'b0001;
    bus.req0_op    = 2'b00;
    bus.req1_valid = 1'b1;
    bus.req1_data  = 4'b1010;
    bus.req1_op    = 2'b10;
    run_op("rr0", 1, 1'b1, 1'b0, 4'b0001, 2'b00, 1'b1);
    run_op("rr1", 3, 1'b0, 1'b1, 4'b1010, 2'b10, 1'b1);
    run_op("rr2", 2, 1'b1, 1'b0, 4'b0001, 2'b00, 1'b1);
    run_op("rr3", 1, 1'b0, 1'b1, 4'b1010, 2'b10, 1'b1);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    #1;

    // Timeout, and done arriving exactly on the timeout cycle
    bus.req1_data = 4'b0111;
    bus.req1_op   = 2'b01;
    to_op("tmo", 1'b1, 1'b0);
    to_op("tmo_done", 1'b0, 1'b1);

    // Consumer stalls the response for 5 cycles
    bus.rsp_ready  = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req0_data  = 4'b0110;
    bus.req0_op    = 2'b01;
    bus.req1_data  = 4'b1001;
    bus.req1_op    = 2'b10;
    #1;
    chk("stall:rdy0", 32'(bus.req0_ready), 32'd1);
    tick();
    bus.req0_valid = 1'b0;
    tick();
    bus.ru_done   = 1'b1;
    bus.ru_result = 1'b1;
    tick();
    bus.ru_done    = 1'b0;
    bus.req1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall:valid", 32'(bus.rsp_valid), 32'd1);
      chk("stall:id", 32'(bus.rsp_id), 32'd0);
      chk("stall:result", 32'(bus.rsp_result), 32'd1);
      chk("stall:error", 32'(bus.rsp_error), 32'd0);
      chk("stall:ru_in", 32'(bus.ru_in), 32'b0110);
      chk("stall:ru_op", 32'(bus.ru_op), 32'b01);
      chk("stall:noready",
          32'(bus.req0_ready | bus.req1_ready), 32'd0);
      bus.ru_done   = (i == 1);
      bus.ru_result = 1'b0;
      tick();
    end
    bus.ru_done   = 1'b0;
    bus.rsp_ready = 1'b1;
    tick();
    chk("stall:done_valid", 32'(bus.rsp_valid), 32'd0);
    chk("stall:rdy1", 32'(bus.req1_ready), 32'd1);
    bus.req1_valid = 1'b0;
    #1;

    // Reset in WAIT abandons the operation
    bus.req0_valid = 1'b1;
    bus.req0_data  = 4'b1100;
    bus.req0_op    = 2'b10;
    #1;
    chk("abort:rdy0", 32'(bus.req0_ready), 32'd1);
    tick();
    bus.req0_valid = 1'b0;
    tick();
    tick();
    do_reset();
    tick();
    bus.ru_done   = 1'b1;
    bus.ru_result = 1'b1;
    tick();
    bus.ru_done   = 1'b0;
    bus.ru_result = 1'b0;
    #1;
    chk("abort:no_rsp", 32'(bus.rsp_valid), 32'd0);
    chk("abort:no_start", 32'(bus.ru_start), 32'd0);
    tick();
    chk("abort:no_rsp2", 32'(bus.rsp_valid), 32'd0);
    bus.req0_valid = 1'b1;
    bus.req0_data  = 4'b0011;
    bus.req0_op    = 2'b00;
    bus.req1_valid = 1'b1;
    bus.req1_data  = 4'b0101;
    bus.req1_op    = 2'b01;
    run_op("after", 2, 1'b1, 1'b0, 4'b0011, 2'b00, 1'b0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
